// File: rtl/regfile_write_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU datapath types and constants. Holds register-file
//                geometry, the hardwired zero-register index and the common
//                address/word typedefs.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile_write_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_decode_if
//  Description : Register-file port bundle. Carries one write port and two
//                combinational read ports.
//  Ports       : wr_en, wr_addr, wr_data      - write port (master drives)
//                rd_addr_a, rd_addr_b         - read indices (master drives)
//                rd_data_a, rd_data_b         - read data (slave drives)
//                master modport: writeback/operand-fetch side
//                slave modport : register file side
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_decode_if
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);

   logic                  wr_en;
   reg_addr_t             wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   reg_addr_t             rd_addr_a;
   reg_addr_t             rd_addr_b;
   logic [DATA_WIDTH-1:0] rd_data_a;
   logic [DATA_WIDTH-1:0] rd_data_b;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b
   );

endinterface : regfile_write_decode_if
`default_nettype wire

// File: rtl/regfile_write_decode_decoder5_32.sv
`default_nettype none
// ============================================================================
//  Module      : decoder5_32
//  Description : Enable-gated 5-to-32 one-hot decoder. Output is all zero when
//                en is low, otherwise exactly bit[addr] is set.
//  Ports       : en     in  1   decode enable
//                addr   in  5   index to decode
//                onehot out 32  one-hot select vector
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder5_32
   import cpu_pkg::*;
(
   input  wire logic                en,
   input  wire reg_addr_t           addr,
   output      logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule : decoder5_32
`default_nettype wire

// File: rtl/regfile_write_decode.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_decode
//  Description : 32 x DATA_WIDTH architectural register file, one write port,
//                two combinational read ports. Register ZERO_REG is hardwired
//                to zero and silently drops writes. No write-to-read bypass.
//  Ports       : clk    in  1  rising-edge clock
//                reset  in  1  synchronous active-high clear of all registers
//                bus    slave modport of regfile_write_decode_if
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_decode
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  wire logic             clk,
   input  wire logic             reset,
   regfile_write_decode_if.slave bus
);

   logic [NUM_REGS-1:0]   w_wr_onehot;
   logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

   decoder5_32 u_dec (
      .en     (bus.wr_en),
      .addr   (bus.wr_addr),
      .onehot (w_wr_onehot)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         // The decoder still raises this enable; it has nothing to load.
         logic w_unused_zero_en;
         assign w_unused_zero_en = w_wr_onehot[i];
         assign w_regs[i]        = '0;
      end else begin : g_store
         logic [DATA_WIDTH-1:0] r_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_q <= '0;
            end else if (w_wr_onehot[i]) begin
               r_q <= bus.wr_data;
            end
         end
         assign w_regs[i] = r_q;
      end
   end

   // Explicit zero select keeps the zero register's behaviour independent of
   // how its array slot is tied off.
   assign bus.rd_data_a = (bus.rd_addr_a == reg_addr_t'(ZERO_REG)) ? '0 : w_regs[bus.rd_addr_a];
   assign bus.rd_data_b = (bus.rd_addr_b == reg_addr_t'(ZERO_REG)) ? '0 : w_regs[bus.rd_addr_b];

endmodule : regfile_write_decode
`default_nettype wire
